fire4_squeeze_ofm_writer: RTL and testbench

- Receiving end of the fire4_squeeze output interface.
- Captures the DSP_NO-wide parallel ofm vector on each fire4_squeeze_sample pulse, then serialises it into the single-port feature-map RAM, one word per cycle, in channel-major layout.
- After WOUT*WOUT pixels have been written, returns the one-cycle ram_feedback pulse that the conv layer uses to qualify its finish flag.
- Sits between fire4_squeeze and the fire4 expand-stage input RAM.

---
 rtl/fire4_squeeze_ofm_writer.sv | 139 +++++++++++++
 tb/tb_fire4_squeeze_ofm_writer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fire4_squeeze_ofm_writer.sv
// Receives the parallel fire4_squeeze output vector and serialises it into the
// expand-stage feature-map RAM in channel-major order, one word per cycle.
module fire4_squeeze_ofm_writer #(
    parameter int WOUT   = 32,
    parameter int DSP_NO = 32,
    parameter int WIDTH  = 16,
    parameter int AW     = $clog2(DSP_NO * WOUT * WOUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire4_squeeze_sample,
    input  logic [WIDTH-1:0] ofm [0:DSP_NO-1],
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             ram_feedback,
    output logic             overflow
);

    localparam int PIXELS = WOUT * WOUT;
    localparam int CW     = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam int PW     = $clog2(PIXELS + 1);

    localparam logic [AW-1:0] PLANE    = AW'(PIXELS);
    localparam logic [CW-1:0] LAST_CH  = CW'(DSP_NO - 1);
    localparam logic [PW-1:0] LAST_PIX = PW'(PIXELS);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    ch, ch_nxt, ch_inc;
    logic [PW-1:0]    pix, pix_nxt, pix_inc;
    logic             capture;
    logic             wr_en_nxt;
    logic [AW-1:0]    wr_addr_nxt;
    logic [WIDTH-1:0] wr_data_nxt;
    logic             fb_nxt;
    logic             ovf_nxt;
    logic [WIDTH-1:0] hold [0:DSP_NO-1];

    assign ch_inc  = ch + 1'b1;
    assign pix_inc = pix + 1'b1;

    // The write outputs always carry the channel currently being written, so
    // the first channel is loaded straight from ofm on the capturing edge and
    // later channels step the address by one plane (no multiplier needed).
    always_comb begin
        state_nxt   = state;
        ch_nxt      = ch;
        pix_nxt     = pix;
        ovf_nxt     = overflow;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        fb_nxt      = 1'b0;
        capture     = 1'b0;

        case (state)
            IDLE: begin
                if (fire4_squeeze_sample) begin
                    capture     = 1'b1;
                    state_nxt   = DRAIN;
                    ch_nxt      = '0;
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = AW'(pix);
                    wr_data_nxt = ofm[0];
                end
            end
            DRAIN: begin
                if (ch != LAST_CH) begin
                    ch_nxt      = ch_inc;
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = wr_addr + PLANE;
                    wr_data_nxt = hold[ch_inc];
                    if (fire4_squeeze_sample) begin
                        ovf_nxt = 1'b1;
                    end
                end else begin
                    pix_nxt = pix_inc;
                    if (pix_inc == LAST_PIX) begin
                        state_nxt = DONE;
                        fb_nxt    = 1'b1;
                    end else if (fire4_squeeze_sample) begin
                        // A sample on the last channel chains straight into the next drain.
                        capture     = 1'b1;
                        ch_nxt      = '0;
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = AW'(pix_inc);
                        wr_data_nxt = ofm[0];
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ch           <= '0;
            pix          <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            ram_feedback <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nxt;
            ch           <= ch_nxt;
            pix          <= pix_nxt;
            wr_en        <= wr_en_nxt;
            wr_addr      <= wr_addr_nxt;
            wr_data      <= wr_data_nxt;
            busy         <= (state_nxt == DRAIN);
            ram_feedback <= fb_nxt;
            overflow     <= ovf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            hold <= ofm;
        end
    end

endmodule

// File: tb/tb_fire4_squeeze_ofm_writer.sv
// Directed bench for fire4_squeeze_ofm_writer: a default-size instance for the
// single-vector layout and a 4x4x4 instance for layer, chaining and error cases.
module tb_fire4_squeeze_ofm_writer;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_sample;
    logic [15:0] a_ofm [0:31];
    logic        a_wr_en, a_busy, a_fb, a_ovf;
    logic [14:0] a_wr_addr;
    logic [15:0] a_wr_data;

    logic        b_sample;
    logic [15:0] b_ofm [0:3];
    logic        b_wr_en, b_busy, b_fb, b_ovf;
    logic [5:0]  b_wr_addr;
    logic [15:0] b_wr_data;

    int vec_count   = 0;
    int err_count   = 0;
    int b_writes    = 0;
    int b_fb_pulses = 0;
    int seen [0:63];

    always #5 clk = ~clk;

    fire4_squeeze_ofm_writer #(.WOUT(32), .DSP_NO(32), .WIDTH(16)) u_dut_a (
        .clk(clk), .rst(rst), .fire4_squeeze_sample(a_sample), .ofm(a_ofm),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .ram_feedback(a_fb), .overflow(a_ovf)
    );

    fire4_squeeze_ofm_writer #(.WOUT(4), .DSP_NO(4), .WIDTH(16)) u_dut_b (
        .clk(clk), .rst(rst), .fire4_squeeze_sample(b_sample), .ofm(b_ofm),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .ram_feedback(b_fb), .overflow(b_ovf)
    );

    // Running tallies of small-instance writes and feedback pulses.
    always @(negedge clk) begin
        if (b_wr_en) b_writes <= b_writes + 1;
        if (b_fb) b_fb_pulses <= b_fb_pulses + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec_count++;
        if (got !== want) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWrite(input int addr, input int data);
        checkOutput("b_wr_en", 32'(b_wr_en), 32'd1);
        checkOutput("b_wr_addr", 32'(b_wr_addr), 32'(addr));
        checkOutput("b_wr_data", 32'(b_wr_data), 32'(data));
    endtask

    // Presents ofm[c] = base + c for one cycle on the small instance.
    task automatic applyStimulus(input logic [15:0] base);
        for (int c = 0; c < 4; c++) b_ofm[c] = 16'(base + 16'(c));
        b_sample = 1'b1;
        tick();
        b_sample = 1'b0;
    endtask

    initial begin
        int idle_wr;
        int w0;
        int fb0;
        int once;
        logic [15:0] base;

        rst      = 1'b1;
        a_sample = 1'b0;
        b_sample = 1'b0;
        for (int i = 0; i < 32; i++) a_ofm[i] = '0;
        for (int i = 0; i < 4; i++) b_ofm[i] = '0;
        for (int i = 0; i < 64; i++) seen[i] = 0;

        $display("[TB] reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("a_rst_wr_en", 32'(a_wr_en), 32'd0);
        checkOutput("a_rst_wr_addr", 32'(a_wr_addr), 32'd0);
        checkOutput("a_rst_wr_data", 32'(a_wr_data), 32'd0);
        checkOutput("a_rst_busy", 32'(a_busy), 32'd0);
        checkOutput("a_rst_fb", 32'(a_fb), 32'd0);
        checkOutput("a_rst_ovf", 32'(a_ovf), 32'd0);
        checkOutput("b_rst_wr_en", 32'(b_wr_en), 32'd0);
        checkOutput("b_rst_wr_addr", 32'(b_wr_addr), 32'd0);
        checkOutput("b_rst_wr_data", 32'(b_wr_data), 32'd0);
        checkOutput("b_rst_busy", 32'(b_busy), 32'd0);
        checkOutput("b_rst_fb", 32'(b_fb), 32'd0);
        checkOutput("b_rst_ovf", 32'(b_ovf), 32'd0);
        idle_wr = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_wr_en || b_wr_en) idle_wr++;
        end
        checkOutput("idle_writes", 32'(idle_wr), 32'd0);

        $display("[TB] single vector, 32x32x32");
        for (int i = 0; i < 32; i++) a_ofm[i] = 16'(16'h0100 + 16'(i));
        a_sample = 1'b1;
        tick();
        a_sample = 1'b0;
        for (int k = 0; k < 32; k++) begin
            checkOutput("a_wr_en", 32'(a_wr_en), 32'd1);
            checkOutput("a_wr_addr", 32'(a_wr_addr), 32'(k * 1024));
            checkOutput("a_wr_data", 32'(a_wr_data), 32'(16'h0100 + k));
            checkOutput("a_busy", 32'(a_busy), 32'd1);
            tick();
        end
        checkOutput("a_end_wr_en", 32'(a_wr_en), 32'd0);
        checkOutput("a_end_busy", 32'(a_busy), 32'd0);

        $display("[TB] back-to-back");
        applyStimulus(16'h0010);
        for (int k = 0; k < 4; k++) begin
            checkWrite(k * 16, 16'h0010 + k);
            if (k < 3) tick();
        end
        applyStimulus(16'h0020);
        for (int k = 0; k < 4; k++) begin
            checkWrite(k * 16 + 1, 16'h0020 + k);
            checkOutput("b2b_ovf", 32'(b_ovf), 32'd0);
            tick();
        end
        checkOutput("b2b_end_wr_en", 32'(b_wr_en), 32'd0);
        checkOutput("b2b_end_busy", 32'(b_busy), 32'd0);

        $display("[TB] overflow");
        tick();
        applyStimulus(16'h0030);
        checkWrite(2, 16'h0030);
        tick();
        checkWrite(18, 16'h0031);
        applyStimulus(16'h0040);
        checkOutput("ovf_set", 32'(b_ovf), 32'd1);
        checkWrite(34, 16'h0032);
        tick();
        checkWrite(50, 16'h0033);
        tick();
        checkOutput("ovf_end_wr_en", 32'(b_wr_en), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("ovf_sticky", 32'(b_ovf), 32'd1);

        $display("[TB] reset mid-drain");
        applyStimulus(16'h0050);
        checkWrite(3, 16'h0050);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_wr_en", 32'(b_wr_en), 32'd0);
        checkOutput("abort_busy", 32'(b_busy), 32'd0);
        checkOutput("abort_ovf", 32'(b_ovf), 32'd0);
        idle_wr = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (b_wr_en) idle_wr++;
        end
        checkOutput("abort_idle_writes", 32'(idle_wr), 32'd0);
        applyStimulus(16'h0060);
        for (int k = 0; k < 4; k++) begin
            checkWrite(k * 16, 16'h0060 + k);
            tick();
        end
        checkOutput("restart_end_wr_en", 32'(b_wr_en), 32'd0);

        $display("[TB] full layer 4x4x4");
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        w0  = b_writes;
        fb0 = b_fb_pulses;
        for (int s = 0; s < 16; s++) begin
            base = 16'(16'h1000 + 16'(s * 16));
            applyStimulus(base);
            for (int k = 0; k < 4; k++) begin
                checkWrite(k * 16 + s, 32'(base) + k);
                if (b_wr_en) seen[b_wr_addr]++;
                if (s == 5 && k == 2) checkOutput("addr_c2_p5", 32'(b_wr_addr), 32'd37);
                tick();
            end
            if (s == 15) begin
                checkOutput("fb_pulse", 32'(b_fb), 32'd1);
                checkOutput("done_wr_en", 32'(b_wr_en), 32'd0);
                tick();
                checkOutput("fb_single", 32'(b_fb), 32'd0);
                for (int i = 0; i < 44; i++) tick();
            end else begin
                for (int i = 0; i < 45; i++) tick();
            end
        end
        once = 0;
        for (int a = 0; a < 64; a++) if (seen[a] == 1) once++;
        checkOutput("addr_once", 32'(once), 32'd64);
        checkOutput("layer_writes", 32'(b_writes - w0), 32'd64);
        checkOutput("layer_fb_pulses", 32'(b_fb_pulses - fb0), 32'd1);

        w0 = b_writes;
        applyStimulus(16'h7777);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("done_no_write", 32'(b_writes - w0), 32'd0);
        checkOutput("done_no_ovf", 32'(b_ovf), 32'd0);
        checkOutput("done_fb_pulses", 32'(b_fb_pulses - fb0), 32'd1);
        checkOutput("done_busy", 32'(b_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
